// File: rtl/mkio_bc_control.sv
// mkio_bc_control: MKIO bus-controller transaction engine; sends one command word,
// then streams buffer data out or collects RT data in, and checks the RT status word.
module mkio_bc_control #(
  parameter int RESP_TIMEOUT = 1100
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd_word,
  output logic        o_tx_ready,
  output logic [15:0] o_tx_data,
  output logic        o_tx_cd,
  input  logic        i_tx_busy,
  input  logic        i_rx_done,
  input  logic [15:0] i_rx_data,
  input  logic        i_rx_cd,
  input  logic        i_parity_error,
  output logic [4:0]  o_mem_rd_addr,
  input  logic [15:0] i_mem_rd_data,
  output logic        o_mem_we,
  output logic [4:0]  o_mem_wr_addr,
  output logic [15:0] o_mem_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_status_word,
  output logic [4:0]  o_err,
  output logic [5:0]  o_word_cnt
);
  typedef enum logic [2:0] {IDLE, SEND_CMD, FETCH, SEND_DATA, WAIT_STATUS, RECV_DATA, FINISH} state_t;
  // One less than the window so done lands exactly RESP_TIMEOUT cycles after the last event
  localparam logic [15:0] TMO_LOAD = 16'(RESP_TIMEOUT - 1);
  state_t      r_state;
  logic [15:0] r_cmd, r_status, r_timer, r_wr_data;
  logic [5:0]  r_n, r_cnt;
  logic [4:0]  r_err, r_wr_addr;
  logic        r_tx_ready, r_busy_q, r_we;
  logic        w_bcast, w_tr, w_tx_end, w_sync_bad, w_rx_bad;
  logic [5:0]  w_cnt_inc, w_n_cmd;
  state_t      w_after_tx;
  assign w_bcast    = r_cmd[15:11] == 5'd31;
  assign w_tr       = r_cmd[10];
  assign w_tx_end   = !r_tx_ready && r_busy_q && !i_tx_busy;
  assign w_cnt_inc  = r_cnt + 6'd1;
  assign w_after_tx = w_bcast ? FINISH : WAIT_STATUS;
  assign w_sync_bad = i_rx_cd != (r_state == WAIT_STATUS);
  assign w_rx_bad   = w_sync_bad || i_parity_error;
  assign w_n_cmd    = (i_cmd_word[9:5] == 5'd0 || i_cmd_word[9:5] == 5'd31) ? 6'd0 :
                      (i_cmd_word[4:0] == 5'd0) ? 6'd32 : {1'b0, i_cmd_word[4:0]};
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_status   <= '0;
      r_timer    <= '0;
      r_wr_data  <= '0;
      r_wr_addr  <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_tx_ready <= 1'b0;
      r_busy_q   <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      r_busy_q <= i_tx_busy;
      r_we     <= 1'b0;
      if (r_tx_ready && i_tx_busy) r_tx_ready <= 1'b0;
      if (r_state != WAIT_STATUS && r_state != RECV_DATA) r_timer <= TMO_LOAD;
      case (r_state)
        IDLE: if (i_cmd_valid) begin
          r_cmd <= i_cmd_word;
          r_n   <= w_n_cmd;
          r_cnt <= '0;
          if (i_cmd_word[15:10] == 6'h3f) begin
            r_err   <= 5'b10000;
            r_state <= FINISH;
          end else begin
            r_err      <= '0;
            r_tx_ready <= 1'b1;
            r_state    <= SEND_CMD;
          end
        end
        SEND_CMD: if (w_tx_end) r_state <= (!w_tr && r_n != 6'd0) ? FETCH : w_after_tx;
        FETCH: begin
          r_tx_ready <= 1'b1;
          r_state    <= SEND_DATA;
        end
        SEND_DATA: if (w_tx_end) begin
          r_cnt   <= w_cnt_inc;
          r_state <= (w_cnt_inc < r_n) ? FETCH : w_after_tx;
        end
        WAIT_STATUS, RECV_DATA:
          if (i_rx_done) begin
            r_timer <= TMO_LOAD;
            if (w_rx_bad) begin
              r_err[2] <= w_sync_bad;
              r_err[1] <= i_parity_error;
              r_state  <= FINISH;
            end else if (r_state == WAIT_STATUS) begin
              r_status <= i_rx_data;
              if (i_rx_data[15:11] != r_cmd[15:11]) begin
                r_err[3] <= 1'b1;
                r_state  <= FINISH;
              end else r_state <= (w_tr && r_n != 6'd0) ? RECV_DATA : FINISH;
            end else begin
              r_we      <= 1'b1;
              r_wr_addr <= r_cnt[4:0];
              r_wr_data <= i_rx_data;
              r_cnt     <= w_cnt_inc;
              if (w_cnt_inc == r_n) r_state <= FINISH;
            end
          end else if (r_timer == 16'd1) begin
            r_err[0] <= 1'b1;
            r_state  <= FINISH;
          end else r_timer <= r_timer - 16'd1;
        default: r_state <= IDLE;
      endcase
    end
  assign o_cmd_ready   = r_state == IDLE && i_reset_n;
  assign o_busy        = r_state != IDLE;
  assign o_done        = r_state == FINISH;
  assign o_tx_ready    = r_tx_ready;
  assign o_tx_cd       = r_state == SEND_CMD;
  assign o_tx_data     = (r_state == SEND_DATA) ? i_mem_rd_data : r_cmd;
  assign o_mem_rd_addr = r_cnt[4:0];
  assign o_mem_we      = r_we;
  assign o_mem_wr_addr = r_wr_addr;
  assign o_mem_wr_data = r_wr_data;
  assign o_status_word = r_status;
  assign o_err         = r_err;
  assign o_word_cnt    = r_cnt;
endmodule

// File: tb/tb_mkio_bc_control.sv
// tb_mkio_bc_control: randomized bench with a transmitter/RT responder model and a
// transaction-level reference for tx words, buffer writes, err, word_cnt and timing.
module tb_mkio_bc_control;
  localparam int RESP_TIMEOUT = 1100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [15:0] cmd_word = '0;
  logic cmd_ready, tx_ready, tx_cd, busy, done, mem_we;
  logic [15:0] tx_data, mem_rd_data, mem_wr_data, status_word;
  logic tx_busy = 1'b0, rx_done = 1'b0, rx_cd = 1'b0, parity_error = 1'b0;
  logic [15:0] rx_data = '0;
  logic [4:0] mem_rd_addr, mem_wr_addr, err;
  logic [5:0] word_cnt;
  always #5 clk = ~clk;
  mkio_bc_control #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_word(cmd_word), .o_tx_ready(tx_ready), .o_tx_data(tx_data), .o_tx_cd(tx_cd),
    .i_tx_busy(tx_busy), .i_rx_done(rx_done), .i_rx_data(rx_data), .i_rx_cd(rx_cd),
    .i_parity_error(parity_error), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data),
    .o_mem_we(mem_we), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
    .o_busy(busy), .o_done(done), .o_status_word(status_word), .o_err(err),
    .o_word_cnt(word_cnt));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_err = 0, n_chk = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  logic [15:0] bc_buf [32];
  always @(posedge clk) mem_rd_data <= bc_buf[mem_rd_addr];
  // Transmitter model: accept on tx_ready, raise busy after 0-2 cycles, hold 3-7 cycles
  int tx_ph = 0, tx_cnt = 0;
  logic [15:0] txq_d[$];
  logic txq_cd[$];
  int txq_cyc[$], fallq[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ph = 0;
      tx_busy = 1'b0;
    end else if (tx_ph == 0) begin
      if (tx_ready) begin
        txq_d.push_back(tx_data);
        txq_cd.push_back(tx_cd);
        txq_cyc.push_back(cyc);
        tx_cnt = $urandom_range(0, 2);
        tx_ph = 1;
      end
    end else if (tx_ph == 1) begin
      if (tx_cnt == 0) begin
        tx_busy = 1'b1;
        tx_cnt = $urandom_range(2, 6);
        tx_ph = 2;
      end else tx_cnt--;
    end else if (tx_cnt == 0) begin
      tx_busy = 1'b0;
      fallq.push_back(cyc);
      tx_ph = 0;
    end else tx_cnt--;
  end
  int wq_a[$];
  logic [15:0] wq_d[$];
  int last_rx_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [4:0] done_err = '0;
  logic [5:0] done_wc = '0;
  logic [15:0] done_st = '0, exp_status = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      wq_a.push_back(int'(mem_wr_addr));
      wq_d.push_back(mem_wr_data);
      check("we_latency", cyc - last_rx_cyc, 1);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
      done_wc = word_cnt;
      done_st = status_word;
    end
  end
  task automatic send_rx(input logic [15:0] d, input logic cd, input logic pe);
    rx_data = d;
    rx_cd = cd;
    parity_error = pe;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
    parity_error = 1'b0;
  endtask
  function automatic int calc_n(input logic [15:0] c);
    if (c[9:5] == 5'd0 || c[9:5] == 5'd31) return 0;
    return (c[4:0] == 5'd0) ? 32 : int'(c[4:0]);
  endfunction
  // mode: 0 normal, 1 no RT response, 2 wrong status addr, 3 parity at word k, 4 sync at word k
  task automatic run(input logic [15:0] cmd, input int mode, input int bad_k);
    logic [4:0] rt, exp_err;
    logic tr, bcast, illegal, rx_sent;
    logic [15:0] st, d;
    logic [15:0] exp_wd[$];
    int n, ntx, g, exp_wc, acc;
    rt = cmd[15:11];
    tr = cmd[10];
    n = calc_n(cmd);
    bcast = rt == 5'd31;
    illegal = bcast && tr;
    ntx = illegal ? 0 : 1 + (tr ? 0 : n);
    exp_err = '0;
    exp_wc = 0;
    rx_sent = 1'b0;
    txq_d = {}; txq_cd = {}; txq_cyc = {}; fallq = {}; wq_a = {}; wq_d = {};
    done_cnt = 0;
    for (int i = 0; i < 32; i++) bc_buf[i] = 16'($urandom);
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    cmd_word = cmd;
    cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (fallq.size() < ntx && g < 5000) begin @(negedge clk); g++; end
    check("tx_words_done", fallq.size(), ntx);
    if (illegal) exp_err = 5'b10000;
    else begin
      if (!tr) exp_wc = n;
      if (!bcast) begin
        if (mode == 1) exp_err = 5'b00001;
        else begin
          repeat ($urandom_range(1, 20)) @(negedge clk);
          st = {(mode == 2) ? rt + 5'd1 : rt, 11'($urandom)};
          send_rx(st, 1'b1, 1'b0);
          exp_status = st;
          rx_sent = 1'b1;
          if (mode == 2) exp_err = 5'b01000;
          else if (tr) for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            d = 16'($urandom);
            if (mode == 3 && k == bad_k) begin
              send_rx(d, 1'b0, 1'b1);
              exp_err = 5'b00010;
              break;
            end
            if (mode == 4 && k == bad_k) begin
              send_rx(d, 1'b1, 1'b0);
              exp_err = 5'b00100;
              break;
            end
            send_rx(d, 1'b0, 1'b0);
            exp_wd.push_back(d);
            exp_wc = k + 1;
          end
        end
      end
    end
    g = 0;
    while (done_cnt == 0 && g < 3000) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    if (illegal) check("done_lat_illegal", done_cyc - acc, 1);
    else if (rx_sent) check("done_lat_rx", done_cyc - last_rx_cyc, 1);
    else if (fallq.size() > 0)
      check(bcast ? "done_lat_bcast" : "done_lat_timeout", done_cyc - fallq[fallq.size() - 1],
            bcast ? 1 : RESP_TIMEOUT);
    check("err", done_err, exp_err);
    check("err_held", err, exp_err);
    check("word_cnt", done_wc, exp_wc);
    check("status_word", done_st, exp_status);
    check("tx_count", txq_d.size(), ntx);
    for (int i = 0; i < txq_d.size() && i < ntx; i++) begin
      check("tx_data", txq_d[i], (i == 0) ? cmd : bc_buf[i - 1]);
      check("tx_cd", txq_cd[i], i == 0);
      if (i == 0) check("tx_lat_cmd", txq_cyc[0] - acc, 1);
      else if (i <= fallq.size()) check("tx_lat_data", txq_cyc[i] - fallq[i - 1], 2);
    end
    check("we_count", wq_d.size(), exp_wd.size());
    for (int i = 0; i < wq_d.size() && i < exp_wd.size(); i++) begin
      check("we_addr", wq_a[i], i);
      check("we_data", wq_d[i], exp_wd[i]);
    end
    check("idle_busy", busy, 0);
    check("idle_ready", cmd_ready, 1);
  endtask
  initial begin
    logic [15:0] c;
    int m, n, g;
    for (int i = 0; i < 32; i++) bc_buf[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_status", status_word, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_mem_we", mem_we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);
    run(16'h0843, 0, 0);
    run(16'h1C40, 0, 0);
    run(16'hF822, 0, 0);
    run(16'h0843, 1, 0);
    run(16'h0C22, 1, 0);
    run(16'h0843, 2, 0);
    run(16'h1C40, 3, $urandom_range(0, 31));
    run(16'h1C40, 4, $urandom_range(0, 31));
    run(16'h0C20, 3, 0);
    run(16'hFC00, 0, 0);
    run(16'h0C1F, 0, 0);
    for (int t = 0; t < 10; t++) begin
      c = 16'($urandom);
      n = calc_n(c);
      m = $urandom_range(0, 4);
      if (c[15:11] == 5'd31 || (m >= 3 && !(c[10] && n > 0))) m = 0;
      run(c, m, (n > 0) ? $urandom_range(0, n - 1) : 0);
    end
    // Reset in the middle of a BC->RT data phase
    done_cnt = 0;
    txq_d = {}; txq_cd = {}; txq_cyc = {}; fallq = {};
    cmd_word = 16'h0845;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (!(txq_d.size() >= 2 && tx_ph != 0) && g < 500) begin @(negedge clk); g++; end
    check("reach_send_data", txq_d.size() >= 2 && tx_ph != 0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_ready", tx_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_status = '0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_tx_ready", tx_ready, 0);
    check("post_rst_err", err, 0);
    check("no_done_on_reset", done_cnt, 0);
    run(16'h0843, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
